// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU: register file, TMP/ACC staging,
// flag latch and a three-step execute stepper behind a valid/ready handshake.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input  logic             wclk,
  input  logic             wreset,
  input  logic             winstr_valid,
  output logic             winstr_ready,
  input  logic [7:0]       binstr,
  input  logic             wwr_en,
  input  logic [1:0]       bwr_sel,
  input  logic [WIDTH-1:0] bwr_data,
  input  logic [1:0]       brd_sel,
  output logic [WIDTH-1:0] brd_data,
  output logic [WIDTH-1:0] balu_a,
  output logic [WIDTH-1:0] balu_b,
  output logic             walu_ci,
  output logic [2:0]       balu_op,
  input  logic [WIDTH-1:0] balu_res,
  input  logic             walu_co,
  input  logic             walu_eq,
  input  logic             walu_al,
  input  logic             walu_z,
  output logic [3:0]       bflags,
  output logic             wdone,
  output logic             werr
);

  typedef enum logic [2:0] {
    IDLE,
    S_TMP,
    S_ACC,
    S_WB,
    S_RET
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] tmp, acc;
  logic [7:0]       ir;
  logic [2:0]       op;
  logic [1:0]       ra, rb;
  logic             accept;

  assign op     = ir[6:4];
  assign ra     = ir[3:2];
  assign rb     = ir[1:0];
  assign accept = winstr_valid && winstr_ready;

  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = binstr[7] ? S_TMP : S_RET;
      S_TMP:   state_next = S_ACC;
      S_ACC:   state_next = S_WB;
      S_WB:    state_next = IDLE;
      S_RET:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      ir  <= '0;
      tmp <= '0;
      acc <= '0;
    end else begin
      if (accept)         ir  <= binstr;
      if (state == S_TMP) tmp <= regs[rb];
      if (state == S_ACC) acc <= balu_res;
    end
  end

  // External writes only land in IDLE, so they can never race a writeback.
  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == IDLE && wwr_en) begin
      regs[bwr_sel] <= bwr_data;
    end else if (state == S_WB && op != 3'd7) begin
      regs[rb] <= acc;
    end
  end

  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset)                            bflags <= 4'b0000;
    else if (state == S_ACC)               bflags <= {walu_co, walu_al, walu_eq, walu_z};
    else if (state == S_RET && ir == 8'h60) bflags <= 4'b0000;
  end

  always_comb begin
    balu_a       = '0;
    balu_b       = '0;
    balu_op      = 3'd0;
    walu_ci      = 1'b0;
    winstr_ready = (state == IDLE);
    wdone        = (state == S_WB) || (state == S_RET);
    werr         = (state == S_RET) && (ir != 8'h60);
    if (state == S_ACC) begin
      balu_a  = regs[ra];
      balu_b  = tmp;
      balu_op = op;
      walu_ci = (op <= 3'd2) ? bflags[3] : 1'b0;
    end
  end

  assign brd_data = regs[brd_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on the
// operand/result ports.
module tb_alu_sequencer;

  logic       wclk = 1'b0;
  logic       wreset;
  logic       winstr_valid;
  logic       winstr_ready;
  logic [7:0] binstr;
  logic       wwr_en;
  logic [1:0] bwr_sel;
  logic [7:0] bwr_data;
  logic [1:0] brd_sel;
  logic [7:0] brd_data;
  logic [7:0] balu_a, balu_b, balu_res;
  logic       walu_ci, walu_co, walu_eq, walu_al, walu_z;
  logic [2:0] balu_op;
  logic [3:0] bflags;
  logic       wdone, werr;

  int checks = 0;
  int errors = 0;

  alu_sequencer dut (
    .wclk(wclk), .wreset(wreset),
    .winstr_valid(winstr_valid), .winstr_ready(winstr_ready), .binstr(binstr),
    .wwr_en(wwr_en), .bwr_sel(bwr_sel), .bwr_data(bwr_data),
    .brd_sel(brd_sel), .brd_data(brd_data),
    .balu_a(balu_a), .balu_b(balu_b), .walu_ci(walu_ci), .balu_op(balu_op),
    .balu_res(balu_res), .walu_co(walu_co), .walu_eq(walu_eq),
    .walu_al(walu_al), .walu_z(walu_z),
    .bflags(bflags), .wdone(wdone), .werr(werr)
  );

  always #5 wclk = ~wclk;

  // Reference ALU: CMP produces a - b with no carry.
  always_comb begin
    balu_res = 8'h00;
    walu_co  = 1'b0;
    case (balu_op)
      3'd0: {walu_co, balu_res} = {1'b0, balu_a} + {1'b0, balu_b} + {8'h00, walu_ci};
      3'd1: begin balu_res = {walu_ci, balu_a[7:1]}; walu_co = balu_a[0]; end
      3'd2: begin balu_res = {balu_a[6:0], walu_ci}; walu_co = balu_a[7]; end
      3'd3: balu_res = ~balu_a;
      3'd4: balu_res = balu_a & balu_b;
      3'd5: balu_res = balu_a | balu_b;
      3'd6: balu_res = balu_a ^ balu_b;
      default: balu_res = balu_a - balu_b;
    endcase
  end

  assign walu_eq = (balu_a == balu_b);
  assign walu_al = (balu_a > balu_b);
  assign walu_z  = (balu_res == 8'h00);

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] instr);
    @(negedge wclk);
    winstr_valid = 1'b1;
    binstr = instr;
    @(posedge wclk);
    #1 winstr_valid = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [7:0] data);
    @(negedge wclk);
    wwr_en = 1'b1;
    bwr_sel = sel;
    bwr_data = data;
    @(posedge wclk);
    #1 wwr_en = 1'b0;
  endtask

  task automatic waitDone(output int cyc, output logic err);
    cyc = 0;
    err = 1'b0;
    while (cyc < 10) begin
      @(negedge wclk);
      cyc++;
      if (wdone) begin
        err = werr;
        break;
      end
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic runInstr(input string tag, input logic [7:0] instr, input int expcyc, input logic experr);
    int   cyc;
    logic err;
    applyStimulus(instr);
    waitDone(cyc, err);
    checkOutput({tag, "_lat"}, 8'(cyc), 8'(expcyc));
    checkOutput({tag, "_err"}, 8'(err), 8'(experr));
  endtask

  task automatic checkReg(input string tag, input logic [1:0] sel, input logic [7:0] expected);
    brd_sel = sel;
    #1;
    checkOutput(tag, brd_data, expected);
  endtask

  initial begin
    int   cyc;
    logic err;
    int   rdycnt, donecnt;

    wreset = 1'b1; winstr_valid = 1'b0; binstr = 8'h00;
    wwr_en = 1'b0; bwr_sel = 2'd0; bwr_data = 8'h00; brd_sel = 2'd0;
    repeat (2) @(negedge wclk);
    checkOutput("rst_ready", 8'(winstr_ready), 8'h01);
    checkOutput("rst_flags", 8'(bflags), 8'h00);
    checkOutput("rst_done", 8'(wdone), 8'h00);
    checkReg("rst_r0", 2'd0, 8'h00);
    wreset = 1'b0;

    // 1: ADD R0,R1
    writeReg(2'd0, 8'h12);
    writeReg(2'd1, 8'h34);
    runInstr("t1_add", 8'h81, 3, 1'b0);
    checkReg("t1_r1", 2'd1, 8'h46);
    checkReg("t1_r0", 2'd0, 8'h12);
    checkOutput("t1_flags", 8'(bflags), 8'h00);

    // 2: ADD with carry out and zero, then CLF
    writeReg(2'd2, 8'hFF);
    writeReg(2'd3, 8'h01);
    runInstr("t2_add", 8'h8B, 3, 1'b0);
    checkReg("t2_r3", 2'd3, 8'h00);
    checkOutput("t2_flags", 8'(bflags), 8'h0D);
    runInstr("t2_clf", 8'h60, 1, 1'b0);
    checkOutput("t2_clf_flags", 8'(bflags), 8'h00);

    // 3: CMP with valid held high for the whole instruction
    writeReg(2'd0, 8'h5A);
    writeReg(2'd1, 8'h5A);
    @(negedge wclk);
    winstr_valid = 1'b1;
    binstr = 8'hF1;
    rdycnt = 0;
    donecnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge wclk);
      if (winstr_ready) rdycnt++;
      if (wdone) donecnt++;
    end
    winstr_valid = 1'b0;
    @(posedge wclk);
    #1;
    checkOutput("t3_accepts", 8'(rdycnt), 8'h01);
    checkOutput("t3_done", 8'(donecnt), 8'h01);
    checkOutput("t3_flags", 8'(bflags), 8'h03);
    checkReg("t3_r1", 2'd1, 8'h5A);

    // 4: carry-in from a previous ADD
    writeReg(2'd2, 8'hFF);
    writeReg(2'd3, 8'h01);
    runInstr("t4_set", 8'h8B, 3, 1'b0);
    checkOutput("t4_set_flags", 8'(bflags), 8'h0D);
    writeReg(2'd0, 8'h10);
    writeReg(2'd1, 8'h20);
    applyStimulus(8'h81);
    @(negedge wclk);
    @(negedge wclk);
    checkOutput("t4_ci", 8'(walu_ci), 8'h01);
    checkOutput("t4_a", balu_a, 8'h10);
    checkOutput("t4_b", balu_b, 8'h20);
    checkOutput("t4_op", 8'(balu_op), 8'h00);
    waitDone(cyc, err);
    checkOutput("t4_lat", 8'(cyc), 8'h01);
    checkReg("t4_r1", 2'd1, 8'h31);
    checkOutput("t4_flags", 8'(bflags), 8'h00);

    // 5: external write during S_ACC is dropped
    applyStimulus(8'h81);
    @(negedge wclk);
    @(negedge wclk);
    wwr_en = 1'b1;
    bwr_sel = 2'd1;
    bwr_data = 8'hAA;
    @(negedge wclk);
    wwr_en = 1'b0;
    checkOutput("t5_done", 8'(wdone), 8'h01);
    @(posedge wclk);
    #1;
    checkReg("t5_r1", 2'd1, 8'h41);
    checkOutput("t5_idle_a", balu_a, 8'h00);

    // Undefined byte leaves registers and flags alone
    writeReg(2'd2, 8'hFF);
    writeReg(2'd3, 8'h01);
    runInstr("t5_set", 8'h8B, 3, 1'b0);
    runInstr("t5_undef", 8'h05, 1, 1'b1);
    checkOutput("t5_undef_flags", 8'(bflags), 8'h0D);
    checkReg("t5_undef_r3", 2'd3, 8'h00);
    checkReg("t5_undef_r2", 2'd2, 8'hFF);

    // 6: reset during S_ACC
    applyStimulus(8'h81);
    @(negedge wclk);
    @(negedge wclk);
    wreset = 1'b1;
    #1;
    checkOutput("t6_ready", 8'(winstr_ready), 8'h01);
    checkOutput("t6_flags", 8'(bflags), 8'h00);
    checkOutput("t6_done", 8'(wdone), 8'h00);
    checkReg("t6_r2", 2'd2, 8'h00);
    checkReg("t6_r1", 2'd1, 8'h00);
    @(negedge wclk);
    checkOutput("t6_done_hold", 8'(wdone), 8'h00);
    wreset = 1'b0;

    // Write coinciding with accept lands before the operand fetch
    writeReg(2'd0, 8'h01);
    @(negedge wclk);
    wwr_en = 1'b1;
    bwr_sel = 2'd1;
    bwr_data = 8'h02;
    winstr_valid = 1'b1;
    binstr = 8'h81;
    @(posedge wclk);
    #1;
    wwr_en = 1'b0;
    winstr_valid = 1'b0;
    waitDone(cyc, err);
    checkOutput("t6_post_lat", 8'(cyc), 8'h03);
    checkReg("t6_post_r1", 2'd1, 8'h03);
    checkReg("t6_post_r0", 2'd0, 8'h01);
    checkOutput("t6_post_flags", 8'(bflags), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
